// File: rtl/exibe_sequencia.sv
// Sequence display unit: plays stored LED codes at addresses 0..limite,
// each lit for T_LIGADO cycles and followed by a T_DESLIGADO blank gap.
// pronto pulses once when the whole round has been shown.
module exibe_sequencia #(
   parameter int unsigned T_LIGADO    = 1000,
   parameter int unsigned T_DESLIGADO = 500
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       inicia,
   input  logic       cancela,
   input  logic [3:0] limite,
   input  logic [3:0] dado_mem,
   output logic [3:0] endereco,
   output logic [3:0] leds,
   output logic       ativo,
   output logic       pronto,
   output logic [3:0] db_estado
);

   localparam int unsigned T_MAX = (T_LIGADO > T_DESLIGADO) ? T_LIGADO : T_DESLIGADO;
   localparam int unsigned CW    = $clog2(T_MAX) + 1;
   localparam logic [CW-1:0] ULT_LIGADO    = CW'(T_LIGADO - 1);
   localparam logic [CW-1:0] ULT_DESLIGADO = CW'(T_DESLIGADO - 1);

   typedef enum logic [2:0] {
      OCIOSO  = 3'd0,
      CARREGA = 3'd1,
      ACENDE  = 3'd2,
      APAGA   = 3'd3,
      PROXIMO = 3'd4,
      FIM     = 3'd5
   } estado_t;

   estado_t       estado_q, estado_d;
   logic [CW-1:0] cont_q, cont_d;
   logic [3:0]    lim_q, lim_d;
   logic [3:0]    endereco_d;
   logic [3:0]    leds_d;
   logic          ativo_d;
   logic          pronto_d;

   // State register plus registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q <= OCIOSO;
         cont_q   <= '0;
         lim_q    <= '0;
         endereco <= '0;
         leds     <= '0;
         ativo    <= 1'b0;
         pronto   <= 1'b0;
      end else begin
         estado_q <= estado_d;
         cont_q   <= cont_d;
         lim_q    <= lim_d;
         endereco <= endereco_d;
         leds     <= leds_d;
         ativo    <= ativo_d;
         pronto   <= pronto_d;
      end
   end

   // Next-state, counter, address and LED logic; cancela overrides everything
   always_comb begin
      estado_d   = estado_q;
      cont_d     = cont_q;
      lim_d      = lim_q;
      endereco_d = endereco;
      leds_d     = leds;

      case (estado_q)
         OCIOSO: begin
            leds_d = '0;
            if (inicia) begin
               estado_d   = CARREGA;
               lim_d      = limite;
               endereco_d = '0;
            end
         end
         CARREGA: begin
            estado_d = ACENDE;
            leds_d   = dado_mem;
            cont_d   = '0;
         end
         ACENDE: begin
            if (cont_q == ULT_LIGADO) begin
               estado_d = APAGA;
               leds_d   = '0;
               cont_d   = '0;
            end else begin
               cont_d = cont_q + CW'(1);
            end
         end
         APAGA: begin
            leds_d = '0;
            if (cont_q == ULT_DESLIGADO) begin
               estado_d = PROXIMO;
            end else begin
               cont_d = cont_q + CW'(1);
            end
         end
         PROXIMO: begin
            leds_d = '0;
            if (endereco == lim_q) begin
               estado_d = FIM;
            end else begin
               estado_d   = CARREGA;
               endereco_d = endereco + 4'd1;
            end
         end
         FIM: begin
            leds_d   = '0;
            estado_d = OCIOSO;
         end
         default: begin
            leds_d   = '0;
            estado_d = OCIOSO;
         end
      endcase

      if (cancela) begin
         estado_d   = OCIOSO;
         leds_d     = '0;
         lim_d      = lim_q;
         endereco_d = endereco;
         cont_d     = cont_q;
      end
   end

   // Status flags follow the state being entered so they line up with it
   always_comb begin
      ativo_d  = 1'b0;
      pronto_d = 1'b0;
      case (estado_d)
         CARREGA, ACENDE, APAGA, PROXIMO: ativo_d  = 1'b1;
         FIM:                             pronto_d = 1'b1;
         default:                         ;
      endcase
   end

   // Debug view of the state register; unused codes read as F
   always_comb begin
      db_estado = 4'hF;
      case (estado_q)
         OCIOSO, CARREGA, ACENDE, APAGA, PROXIMO, FIM: db_estado = {1'b0, estado_q};
         default:                                      db_estado = 4'hF;
      endcase
   end

endmodule

// File: tb/tb_exibe_sequencia.sv
// Testbench for exibe_sequencia with short timings (T_LIGADO=4, T_DESLIGADO=2).
module tb_exibe_sequencia;

   localparam int TL = 4;
   localparam int TD = 2;
   localparam int P  = TL + TD + 2;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       inicia = 1'b0;
   logic       cancela = 1'b0;
   logic [3:0] limite = '0;
   logic [3:0] dado_mem;
   logic [3:0] endereco;
   logic [3:0] leds;
   logic       ativo;
   logic       pronto;
   logic [3:0] db_estado;

   logic [3:0] mem     [16];
   logic [3:0] ref_mem [16];

   int checks = 0;
   int errors = 0;

   assign dado_mem = mem[endereco];

   exibe_sequencia #(.T_LIGADO(TL), .T_DESLIGADO(TD)) dut (
      .clock     (clock),
      .reset     (reset),
      .inicia    (inicia),
      .cancela   (cancela),
      .limite    (limite),
      .dado_mem  (dado_mem),
      .endereco  (endereco),
      .leds      (leds),
      .ativo     (ativo),
      .pronto    (pronto),
      .db_estado (db_estado)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [3:0] one_hot_rand();
      int b;
      b = int'($urandom_range(0, 3));
      return 4'(1 << b);
   endfunction

   function automatic void fill_mem();
      for (int i = 0; i < 16; i++) mem[i] = one_hot_rand();
   endfunction

   // Phase of the run after edge n (edge 1 samples inicia): returns state code and item index
   function automatic void fase(input int n, input int lim, output int st, output int idx);
      int fim, r;
      fim = (lim + 1) * P + 1;
      if (n > fim) begin
         st = 0; idx = lim;
      end else if (n == fim) begin
         st = 5; idx = lim;
      end else begin
         idx = (n - 1) / P;
         r   = (n - 1) % P;
         if (r == 0)            st = 1;
         else if (r <= TL)      st = 2;
         else if (r <= TL + TD) st = 3;
         else                   st = 4;
      end
   endfunction

   // Expected {endereco, leds, ativo, pronto, db_estado} after edge n
   function automatic logic [13:0] esperado(input int n, input int lim);
      int st, idx;
      logic [3:0] l;
      fase(n, lim, st, idx);
      l = (st == 2) ? ref_mem[idx] : 4'd0;
      return {4'(idx), l, (st >= 1 && st <= 4), (st == 5), 4'(st)};
   endfunction

   task automatic test_reset();
      #3;
      checks++;
      if ({endereco, leds, ativo, pronto, db_estado} !== 14'd0) begin
         errors++;
         $display("FAIL reset_state: got %h required %h", {endereco, leds, ativo, pronto, db_estado}, 14'd0);
      end
      #10 reset = 1'b0;
      step();
   endtask

   // Full run for limite=lim; optionally rewrite memory while an item is lit
   task automatic test_sequence(input int lim, input bit scramble);
      int st, idx, fim;
      logic [13:0] exp_v, got_v;
      for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];
      fim = (lim + 1) * P + 1;
      limite = 4'(lim);
      inicia = 1'b1;
      step();
      inicia = 1'b0;
      limite = 4'($urandom_range(0, 15));
      for (int n = 1; n <= fim + 1; n++) begin
         exp_v = esperado(n, lim);
         got_v = {endereco, leds, ativo, pronto, db_estado};
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL seq_lim%0d edge %0d: got %h required %h", lim, n, got_v, exp_v);
         end
         fase(n, lim, st, idx);
         if (scramble && st == 2) mem[idx] = one_hot_rand();
         if (n <= fim) step();
      end
   endtask

   task automatic test_cancel();
      logic [13:0] exp_v, got_v;
      int pulses;
      fill_mem();
      for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];
      limite = 4'd3;
      inicia = 1'b1;
      step();
      inicia = 1'b0;
      for (int n = 2; n <= 10; n++) step();
      exp_v = esperado(10, 3);
      got_v = {endereco, leds, ativo, pronto, db_estado};
      checks++;
      if (got_v !== exp_v) begin
         errors++;
         $display("FAIL cancel_pre: got %h required %h", got_v, exp_v);
      end
      cancela = 1'b1;
      step();
      cancela = 1'b0;
      got_v = {endereco, leds, ativo, pronto, db_estado};
      checks++;
      if (got_v !== {4'd1, 4'd0, 1'b0, 1'b0, 4'd0}) begin
         errors++;
         $display("FAIL cancel_post: got %h required %h", got_v, {4'd1, 4'd0, 1'b0, 1'b0, 4'd0});
      end
      pulses = 0;
      for (int n = 0; n < 40; n++) begin
         step();
         if (pronto !== 1'b0 || db_estado !== 4'd0) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL cancel_idle: got %0d non-idle cycles required 0", pulses);
      end
      inicia  = 1'b1;
      cancela = 1'b1;
      step();
      inicia  = 1'b0;
      cancela = 1'b0;
      checks++;
      if (db_estado !== 4'd0 || ativo !== 1'b0) begin
         errors++;
         $display("FAIL cancel_priority: got state %h ativo %b required 0 0", db_estado, ativo);
      end
   endtask

   task automatic test_inicia_held();
      logic [13:0] exp_v, got_v;
      int fim, pulses;
      fill_mem();
      for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];
      fim = 3 * P + 1;
      pulses = 0;
      limite = 4'd2;
      inicia = 1'b1;
      step();
      for (int n = 1; n <= fim + 1; n++) begin
         if (n == 10) limite = 4'd5;
         if (pronto === 1'b1) pulses++;
         exp_v = esperado(n, 2);
         got_v = {endereco, leds, ativo, pronto, db_estado};
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL held edge %0d: got %h required %h", n, got_v, exp_v);
         end
         step();
      end
      checks++;
      if (db_estado !== 4'd1 || endereco !== 4'd0 || ativo !== 1'b1) begin
         errors++;
         $display("FAIL held_restart: got state %h addr %h ativo %b required 1 0 1", db_estado, endereco, ativo);
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL held_pronto_count: got %0d required 1", pulses);
      end
      inicia  = 1'b0;
      cancela = 1'b1;
      step();
      cancela = 1'b0;
      step();
   endtask

   task automatic test_async_reset();
      logic [13:0] exp_v, got_v;
      fill_mem();
      for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];
      limite = 4'd3;
      inicia = 1'b1;
      step();
      inicia = 1'b0;
      for (int n = 2; n <= 22; n++) step();
      exp_v = esperado(22, 3);
      got_v = {endereco, leds, ativo, pronto, db_estado};
      checks++;
      if (got_v !== exp_v) begin
         errors++;
         $display("FAIL areset_pre: got %h required %h", got_v, exp_v);
      end
      #2 reset = 1'b1;
      #1;
      got_v = {endereco, leds, ativo, pronto, db_estado};
      checks++;
      if (got_v !== 14'd0) begin
         errors++;
         $display("FAIL areset_immediate: got %h required %h", got_v, 14'd0);
      end
      #1 reset = 1'b0;
      step();
   endtask

   initial begin
      fill_mem();
      test_reset();
      mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd4; mem[3] = 4'd8;
      test_sequence(0, 1'b0);
      step();
      test_sequence(2, 1'b0);
      step();
      for (int k = 0; k < 4; k++) begin
         fill_mem();
         test_sequence(int'($urandom_range(0, 6)), 1'b1);
      end
      test_cancel();
      test_inicia_held();
      test_async_reset();
      fill_mem();
      test_sequence(int'($urandom_range(1, 5)), 1'b0);
      fill_mem();
      test_sequence(15, 1'b1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
